morse_keyer: RTL and testbench
==============================

MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 Parameter: UNIT_CYCLES, default 5_000_000, clock cycles per Morse time unit (legal range 2..2^24).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 code_in  input  8  code word: [7:5] length/type field, [4:0] element pattern.
REQ-005 code_valid  input  1  code_in is valid this cycle.
REQ-006 code_ready  output  1  keyer can accept a code this cycle.
REQ-007 key_out  output  1  keyed carrier: 1 = mark, 0 = silence.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse when an ETX code is accepted.
REQ-010 err  output  1  one-cycle pulse when an invalid code (type 000) is accepted.

Function
REQ-011 Handshake: transfer occurs on a rising edge with code_valid=1 and code_ready=1; code_ready=1 only in IDLE; code_in is latched at transfer and ignored at all other times.
REQ-012 Type field: 001..101 = letter/digit of 1..5 elements; 110 = word space; 111 = ETX; 000 = invalid.
REQ-013 Element order: MSB-first within the used bits, bit[len-1] first and bit[0] last; 1 = dash, 0 = dot.
REQ-014 Timing: dot mark = 1 unit; dash mark = 3 units; inter-element gap = 1 unit; a 3-unit letter gap follows the last element.
REQ-015 Word space: 4 units of silence with no mark, giving 7 units of silence after a preceding letter gap.
REQ-016 ETX: done=1 in the cycle after transfer; no keying; return to IDLE in that same cycle.
REQ-017 Invalid code: err=1 in the cycle after transfer; no keying; return to IDLE in that same cycle.
REQ-018 States: IDLE -> MARK (letter), IDLE -> WORD_GAP (space), IDLE -> IDLE with pulse (ETX/invalid).
REQ-019 State transitions: MARK -> EL_GAP if elements remain, else MARK -> LETTER_GAP; EL_GAP -> MARK; LETTER_GAP -> IDLE; WORD_GAP -> IDLE.
REQ-020 key_out is registered and equals 1 exactly while in MARK; the first mark cycle is the cycle after transfer.
REQ-021 Unit timebase restarts at every transfer, so every duration is an exact multiple of UNIT_CYCLES with no phase error.
REQ-022 Counters: cycle counter of width clog2(UNIT_CYCLES); unit counter of 3 bits (max 4); element index of 3 bits; none may wrap during a legal sequence.
REQ-023 code_valid held high while busy has no effect; back-to-back codes start with no idle cycle beyond the one code_ready cycle.

Reset
REQ-024 Reset outputs: key_out=0, code_ready=1, busy=0, done=0, err=0; state IDLE; all counters 0.
REQ-025 Reset asserted mid-operation (including mid-mark) forces key_out=0 immediately (asynchronously) and discards the latched code.

Structure
REQ-026 Shared include file holds type-field constants (TYPE_INVALID, TYPE_SPACE, TYPE_ETX), unit-count constants (DOT=1, DASH=3, EL_GAP=1, LETTER_GAP=3, WORD_GAP=4) and state encodings.
REQ-027 One sub-module, morse_unit_timer: a restartable UNIT_CYCLES prescaler producing a one-cycle unit_tick.
REQ-028 The FSM, latched code register and unit/element counters stay in morse_keyer.

Verification (UNIT_CYCLES=4, transfer at cycle 0)
REQ-029 Scenario 'E' (0x20): key_out high for cycles 1-4, low for cycles 5-16, code_ready=1 at cycle 17.
REQ-030 Scenario 'A' (0x41): key_out high for cycles 1-4, low for 5-8, high for 9-20, low for 21-32, then IDLE.
REQ-031 Scenario space (0xC0) then 'T' (0x21): 16 silent cycles, then a 12-cycle mark, with no extra gap inserted.
REQ-032 Scenario ETX (0xE0) and invalid (0x00): one-cycle done and err pulses respectively, key_out stays 0, code_ready=1 the following cycle.
REQ-033 Scenario '0' (0xBF) with rst pulsed at cycle 20: key_out falls within the reset cycle, all outputs return to reset values, and the next 'E' is keyed correctly.

Source files
------------

// File: rtl/morse_keyer_pkg.sv
// Shared constants for the Morse keyer: code type fields, element/gap lengths
// in time units, and FSM state encodings.
package morse_keyer_pkg;

    localparam logic [2:0] TYPE_INVALID = 3'b000;
    localparam logic [2:0] TYPE_SPACE   = 3'b110;
    localparam logic [2:0] TYPE_ETX     = 3'b111;

    localparam logic [2:0] DOT        = 3'd1;
    localparam logic [2:0] DASH       = 3'd3;
    localparam logic [2:0] EL_GAP     = 3'd1;
    localparam logic [2:0] LETTER_GAP = 3'd3;
    localparam logic [2:0] WORD_GAP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_EL_GAP,
        S_LETTER_GAP,
        S_WORD_GAP
    } state_e;

    function automatic logic is_letter(input logic [2:0] code_type);
        return (code_type >= 3'b001) && (code_type <= 3'b101);
    endfunction

endpackage

// File: rtl/morse_keyer_if.sv
// Code handshake and keyer status signals; the code source is the master,
// the keyer is the slave.
interface morse_keyer_if;
    logic [7:0] code_in;
    logic       code_valid;
    logic       code_ready;
    logic       key_out;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output code_in, code_valid,
        input  code_ready, key_out, busy, done, err
    );

    modport slave (
        input  code_in, code_valid,
        output code_ready, key_out, busy, done, err
    );
endinterface

// File: rtl/morse_unit_timer.sv
// Restartable prescaler: unit_tick_o is high in the last clock of every
// UNIT_CYCLES-long unit, counted from the most recent restart.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic unit_tick_o
);
    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign unit_tick_o = (cnt_q == LAST) && !restart_i;

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts one code word per handshake and keys it out with
// standard dot/dash/gap timing derived from a restartable unit timebase.
module morse_keyer
    import morse_keyer_pkg::*;
#(
    parameter int UNIT_CYCLES = 5_000_000
) (
    input  logic          clk,
    input  logic          rst,
    morse_keyer_if.slave  bus
);
    state_e     state_q, state_d;
    logic [7:0] pat_q,   pat_d;
    logic [2:0] unit_q,  unit_d;
    logic [2:0] el_q,    el_d;
    logic       key_q,   key_d;
    logic       done_q,  done_d;
    logic       err_q,   err_d;

    logic       transfer;
    logic       unit_tick;
    logic [2:0] unit_target;
    logic       unit_last;
    logic [2:0] code_type;

    assign code_type = bus.code_in[7:5];
    assign transfer  = bus.code_valid && (state_q == S_IDLE);

    // Timebase phase is reset on every accepted code so durations are exact.
    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .restart_i   (transfer),
        .unit_tick_o (unit_tick)
    );

    always_comb begin
        unit_target = DOT;
        case (state_q)
            S_MARK:       unit_target = pat_q[el_q] ? DASH : DOT;
            S_EL_GAP:     unit_target = EL_GAP;
            S_LETTER_GAP: unit_target = LETTER_GAP;
            S_WORD_GAP:   unit_target = WORD_GAP;
            default:      unit_target = DOT;
        endcase
    end

    assign unit_last = unit_tick && (unit_q == (unit_target - 3'd1));

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        unit_d  = unit_q;
        el_d    = el_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (state_q == S_IDLE) begin
            if (transfer) begin
                unit_d = '0;
                el_d   = '0;
                if (code_type == TYPE_INVALID) begin
                    err_d = 1'b1;
                end else if (code_type == TYPE_ETX) begin
                    done_d = 1'b1;
                end else if (code_type == TYPE_SPACE) begin
                    state_d = S_WORD_GAP;
                end else if (is_letter(code_type)) begin
                    pat_d   = {3'b000, bus.code_in[4:0]};
                    el_d    = code_type - 3'd1;
                    state_d = S_MARK;
                end
            end
        end else if (unit_tick) begin
            if (!unit_last) begin
                unit_d = unit_q + 3'd1;
            end else begin
                unit_d = '0;
                case (state_q)
                    S_MARK: begin
                        if (el_q == 3'd0) begin
                            state_d = S_LETTER_GAP;
                        end else begin
                            el_d    = el_q - 3'd1;
                            state_d = S_EL_GAP;
                        end
                    end
                    S_EL_GAP:     state_d = S_MARK;
                    S_LETTER_GAP: state_d = S_IDLE;
                    S_WORD_GAP:   state_d = S_IDLE;
                    default:      state_d = S_IDLE;
                endcase
            end
        end

        key_d = (state_d == S_MARK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            unit_q  <= '0;
            el_q    <= '0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            unit_q  <= unit_d;
            el_q    <= el_d;
            key_q   <= key_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.code_ready = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.key_out    = key_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: directed scenarios plus random codes, each compared
// cycle by cycle against a keying timeline computed from the Morse rules.
module tb_morse_keyer;
    localparam int U = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    morse_keyer_if bus ();

    morse_keyer #(
        .UNIT_CYCLES (U)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observed vector order: key_out, busy, code_ready, done, err
    logic [4:0] obs;
    assign obs = {bus.key_out, bus.busy, bus.code_ready, bus.done, bus.err};

    bit model_q[$];

    task automatic chk(input string tag, input int cyc, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b (key,busy,ready,done,err)",
                   tag, cyc, obs, exp);
        end
    endtask

    // Per-cycle key level after a transfer, built straight from element rules.
    function automatic void build(input logic [7:0] c);
        int len;
        model_q.delete();
        len = int'(c[7:5]);
        if (len >= 1 && len <= 5) begin
            for (int i = len - 1; i >= 0; i--) begin
                for (int j = 0; j < (c[i] ? 3 : 1) * U; j++) model_q.push_back(1'b1);
                if (i > 0) for (int j = 0; j < U; j++) model_q.push_back(1'b0);
            end
            for (int j = 0; j < 3 * U; j++) model_q.push_back(1'b0);
        end else if (len == 6) begin
            for (int j = 0; j < 4 * U; j++) model_q.push_back(1'b0);
        end
    endfunction

    task automatic wait_ready(input string tag);
        int w = 0;
        while (bus.code_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        assert (bus.code_ready === 1'b1) else begin
            failures++;
            $error("FAIL %s ready_wait observed=%b expected=1", tag, bus.code_ready);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first idle cycle.
    task automatic send(input string tag, input logic [7:0] c, input bit noise);
        int n;
        logic [2:0] t;
        logic [4:0] exp;
        build(c);
        n = model_q.size();
        t = c[7:5];
        wait_ready(tag);
        bus.code_in    = c;
        bus.code_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (k <= n) exp = {model_q[k-1], 1'b1, 1'b0, 1'b0, 1'b0};
            else        exp = {1'b0, 1'b0, 1'b1, (t == 3'b111), (t == 3'b000)};
            chk(tag, k, exp);
            if (k <= n) begin
                bus.code_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.code_in    = 8'($urandom);
            end else begin
                bus.code_valid = 1'b0;
            end
        end
        $display("tx %s code=0x%02h cycles=%0d checks=%0d failures=%0d", tag, c, n, checks, failures);
        if (n == 0) begin
            @(negedge clk);
            chk({tag, "_after"}, n + 2, 5'b00100);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] exp;
        bus.code_in    = 8'h00;
        bus.code_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("reset_async", 0, 5'b00100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", 0, 5'b00100);

        send("E",     8'h20, 1'b0);
        send("A",     8'h41, 1'b1);
        send("SPACE", 8'hC0, 1'b0);
        send("T",     8'h21, 1'b0);
        send("ETX",   8'hE0, 1'b0);
        send("INV",   8'h00, 1'b1);

        // Digit zero (five dashes), interrupted by reset during its second mark.
        build(8'hBF);
        wait_ready("ZERO");
        bus.code_in    = 8'hBF;
        bus.code_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            bus.code_valid = 1'b0;
            exp = {model_q[k-1], 1'b1, 1'b0, 1'b0, 1'b0};
            chk("ZERO", k, exp);
        end
        @(posedge clk);
        #1 chk("ZERO_premark", 20, {model_q[19], 4'b1000});
        #1 rst = 1'b1;
        #1 chk("ZERO_rst_async", 20, 5'b00100);
        @(negedge clk);
        chk("ZERO_rst_hold", 20, 5'b00100);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("ZERO_rst_release", 21, 5'b00100);
        $display("tx ZERO code=0xbf reset_at=20 checks=%0d failures=%0d", checks, failures);

        send("E_after_rst", 8'h20, 1'b0);

        for (int r = 0; r < 25; r++) begin
            send("RND", 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
